// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Used by the RTL and by the bench scoreboard.
package fifo_pkg;

  // Fill counter needs one extra bit so it can represent DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic vacio;
    logic lleno;
    logic casi_vacio;
    logic casi_lleno;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_ram_dp.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Read data follows raddr combinationally and returns the pre-write word on an address collision.
module fifo_ram_dp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with fill level, programmable almost flags, sticky errors and optional FWFT.
// Reads: 1-cycle registered (FWFT=0) or combinational head (FWFT=1); writes are rejected only when full without a read.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       data_out,
  output logic                   vacio,
  output logic                   lleno,
  output logic                   casi_vacio,
  output logic                   casi_lleno,
  output logic [$clog2(DEPTH):0] usedw,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_sync_flags: WIDTH must be >= 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_flags: DEPTH must be a power of two >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_sync_flags: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_flags: AE_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("fifo_sync_flags: FWFT must be 0 or 1");
  end

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf_q;
  logic             unf_q;
  logic             flush;
  logic             rd_ok;
  logic             wr_ok;
  logic [WIDTH-1:0] rdata;
  fifo_flags_t      flags;

  // rst and clear have identical effect, so a single flush term covers both.
  assign flush = rst | clear;
  assign rd_ok = rd_en && !flags.vacio;
  assign wr_ok = wr_en && (!flags.lleno || rd_ok);

  fifo_ram_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok && !flush),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wr_en && !wr_ok) begin
        ovf_q <= 1'b1;
      end
      if (rd_en && !rd_ok) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign flags = '{
    vacio:      (cnt == '0),
    lleno:      (cnt == FULL_LVL),
    casi_vacio: (cnt <= AE_LVL),
    casi_lleno: (cnt >= AF_LVL),
    overflow:   ovf_q,
    underflow:  unf_q
  };

  assign vacio      = flags.vacio;
  assign lleno      = flags.lleno;
  assign casi_vacio = flags.casi_vacio;
  assign casi_lleno = flags.casi_lleno;
  assign overflow   = flags.overflow;
  assign underflow  = flags.underflow;
  assign usedw      = cnt;

  if (FWFT != 0) begin : g_fwft
    // Forced to zero while empty so the output matches the reset value.
    assign data_out = flags.vacio ? '0 : rdata;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (flush) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= rdata;
      end
    end

    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags, driving an FWFT=0 and an FWFT=1 instance with identical stimulus.
// A queue model is compared against both every cycle, alongside hand-computed literal expectations.
module tb_fifo_sync_flags;
  import fifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] data_in = '0;

  logic [WIDTH-1:0] do_a, do_b;
  logic             vacio_a, lleno_a, cv_a, cl_a, ovf_a, unf_a;
  logic             vacio_b, lleno_b, cv_b, cl_b, ovf_b, unf_b;
  logic [5:0]       usedw_a, usedw_b;

  int tests = 0;
  int fails = 0;

  fifo_sync_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(do_a), .vacio(vacio_a), .lleno(lleno_a), .casi_vacio(cv_a), .casi_lleno(cl_a),
    .usedw(usedw_a), .overflow(ovf_a), .underflow(unf_a)
  );

  fifo_sync_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(do_b), .vacio(vacio_b), .lleno(lleno_b), .casi_vacio(cv_b), .casi_lleno(cl_b),
    .usedw(usedw_b), .overflow(ovf_b), .underflow(unf_b)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c, input logic s);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    clear   = c;
    rst     = s;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_dout_a"}, 32'(do_a), 32'h0);
    chk({tag, "_dout_b"}, 32'(do_b), 32'h0);
    chk({tag, "_vacio"}, 32'({vacio_a, vacio_b}), 32'h3);
    chk({tag, "_lleno"}, 32'({lleno_a, lleno_b}), 32'h0);
    chk({tag, "_casi_vacio"}, 32'({cv_a, cv_b}), 32'h3);
    chk({tag, "_casi_lleno"}, 32'({cl_a, cl_b}), 32'h0);
    chk({tag, "_usedw_a"}, 32'(usedw_a), 32'h0);
    chk({tag, "_usedw_b"}, 32'(usedw_b), 32'h0);
    chk({tag, "_errors"}, 32'({ovf_a, unf_a, ovf_b, unf_b}), 32'h0);
  endtask

  // Reference model: a queue of accepted words plus sticky flags and the last popped word.
  initial begin
    logic [7:0]  mq [$];
    logic        m_ovf, m_unf, rok, wok;
    logic [7:0]  m_dout;
    logic        c_rst, c_clr, c_wr, c_rd;
    logic [7:0]  c_din;
    fifo_flags_t exp_f, got_a, got_b;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = 8'h00;
    forever begin
      @(posedge clk);
      c_rst = rst;
      c_clr = clear;
      c_wr  = wr_en;
      c_rd  = rd_en;
      c_din = data_in;
      @(negedge clk);
      if (c_rst || c_clr) begin
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = 8'h00;
      end else begin
        rok = c_rd && (mq.size() != 0);
        wok = c_wr && ((mq.size() < DEPTH) || rok);
        if (c_rd && !rok) m_unf = 1'b1;
        if (c_wr && !wok) m_ovf = 1'b1;
        if (rok) m_dout = mq.pop_front();
        if (wok) mq.push_back(c_din);
      end
      exp_f = '{
        vacio:      (mq.size() == 0),
        lleno:      (mq.size() == DEPTH),
        casi_vacio: (mq.size() <= 4),
        casi_lleno: (mq.size() >= 28),
        overflow:   m_ovf,
        underflow:  m_unf
      };
      got_a = '{vacio: vacio_a, lleno: lleno_a, casi_vacio: cv_a, casi_lleno: cl_a,
                overflow: ovf_a, underflow: unf_a};
      got_b = '{vacio: vacio_b, lleno: lleno_b, casi_vacio: cv_b, casi_lleno: cl_b,
                overflow: ovf_b, underflow: unf_b};
      chk("model_flags_a", 32'(got_a), 32'(exp_f));
      chk("model_flags_b", 32'(got_b), 32'(exp_f));
      chk("model_usedw_a", 32'(usedw_a), 32'(mq.size()));
      chk("model_usedw_b", 32'(usedw_b), 32'(mq.size()));
      chk("model_dout_a", 32'(do_a), 32'(m_dout));
      if (mq.size() != 0) begin
        chk("model_head_b", 32'(do_b), 32'(mq[0]));
      end
    end
  end

  initial begin
    int         lvl;
    int         toggles;
    logic       up;
    logic       prev_cv;
    logic [7:0] wseq;

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_reset("reset");

    // Fill and drain
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("fill_usedw", 32'(usedw_a), 32'(i + 1));
      chk("fill_casi_lleno", 32'(cl_a), 32'((i + 1) >= 28));
    end
    chk("fill_lleno", 32'({lleno_a, lleno_b}), 32'h3);

    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("ovf_flag", 32'({ovf_a, ovf_b}), 32'h3);
    chk("ovf_usedw", 32'(usedw_a), 32'd32);

    for (int i = 0; i < 32; i++) begin
      chk("drain_head_b", 32'(do_b), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_data_a", 32'(do_a), 32'(i));
    end
    chk("drain_vacio", 32'(vacio_a), 32'h1);
    chk("drain_usedw", 32'(usedw_a), 32'h0);
    chk("ovf_sticky", 32'(ovf_a), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovf_cleared", 32'({ovf_a, ovf_b}), 32'h0);

    // Simultaneous read and write on empty
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("unf_flag", 32'({unf_a, unf_b}), 32'h3);
    chk("unf_usedw", 32'(usedw_a), 32'h1);
    chk("unf_head_b", 32'(do_b), 32'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("unf_read_a", 32'(do_a), 32'h55);
    chk("unf_vacio", 32'(vacio_a), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Simultaneous read and write on full
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    chk("full_rw_usedw", 32'(usedw_a), 32'd32);
    chk("full_rw_no_ovf", 32'({ovf_a, ovf_b}), 32'h0);
    chk("full_rw_data", 32'(do_a), 32'h40);
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("full_rw_drain", 32'(do_a), 32'(8'h40 + i));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("full_rw_last", 32'(do_a), 32'hC3);
    chk("full_rw_vacio", 32'(vacio_a), 32'h1);

    // Wrap-around with the level held between 3 and 6
    wseq = 8'h80;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, wseq, 1'b0, 1'b0, 1'b0);
      wseq = wseq + 8'h01;
    end
    lvl     = 3;
    up      = 1'b1;
    toggles = 0;
    prev_cv = cv_a;
    for (int c = 0; c < 100; c++) begin
      if (c % 7 == 3) begin
        step(1'b1, wseq, 1'b1, 1'b0, 1'b0);
        wseq = wseq + 8'h01;
      end else if (up) begin
        step(1'b1, wseq, 1'b0, 1'b0, 1'b0);
        wseq = wseq + 8'h01;
        lvl++;
      end else begin
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        lvl--;
      end
      if (lvl == 6) up = 1'b0;
      if (lvl == 3) up = 1'b1;
      chk("wrap_usedw", 32'(usedw_a), 32'(lvl));
      chk("wrap_casi_vacio", 32'(cv_a), 32'(lvl <= 4));
      if (cv_a != prev_cv) toggles++;
      prev_cv = cv_a;
    end
    chk("wrap_toggled", 32'(toggles > 0), 32'h1);

    // FWFT head visibility and mid-burst reset
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk("fwft_vacio_fall", 32'(vacio_b), 32'h0);
    chk("fwft_head", 32'(do_b), 32'h11);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("fwft_pop_vacio", 32'(vacio_b), 32'h1);
    step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
    chk("fwft_burst_head", 32'(do_b), 32'h21);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    check_reset("mid_rst");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
